// File: rtl/int_arbiter.sv
// int_arbiter: prioritised interrupt arbiter with a vectored CPU handshake.
// Flow: IDLE -> (INTack) GRANT -> (VECread) CLEAR -> HOLD -> IDLE.
// A GRANT that waits too long for VECread goes to HOLD and pulses TOerr.
// Optional feature macro: INT_ARBITER_NMI_EN adds the NMIreq input and an
// edge-triggered NMI that outranks every maskable source and ignores GIE.
`timescale 1ns/1ps
module int_arbiter #(
  parameter int                   SRC_COUNT    = 8,
  parameter logic [15:0]          VEC_TOP      = 16'hFFFC,
  parameter logic [SRC_COUNT-1:0] AUTOCLR_MASK = {SRC_COUNT{1'b0}},
  parameter int                   TIMEOUT      = 15
) (
  input  logic                 MCLK,
  input  logic                 RSTn,
  input  logic [SRC_COUNT-1:0] INTreq,
  input  logic                 GIE,
  input  logic                 INTack,
  input  logic                 VECread,
`ifdef INT_ARBITER_NMI_EN
  input  logic                 NMIreq,
`endif
  output logic                 IRQ,
  output logic                 VECvalid,
  output logic [15:0]          VECaddr,
  output logic [3:0]           INTidx,
  output logic [SRC_COUNT-1:0] INTclr,
  output logic                 TOerr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CLEAR = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);
  localparam logic [3:0] NMI_IDX   = 4'hF;

  state_t               state_q, state_d;
  logic [3:0]           intidx_q, intidx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 vecvalid_q, vecvalid_d;
  logic [15:0]          vecaddr_q, vecaddr_d;
  logic [SRC_COUNT-1:0] intclr_q, intclr_d;
  logic                 toerr_q, toerr_d;

  logic [3:0]           pick_s;
  logic                 nmi_pend_s;
  logic                 irq_s;

  // Vector slot for a granted index: sources sit just below VEC_TOP, the
  // highest index closest to it; only the NMI index maps onto VEC_TOP.
  function automatic logic [15:0] vec_addr(input logic [3:0] idx);
    logic [15:0] offset;
    offset = (16'(SRC_COUNT) - {12'h000, idx}) << 1;
`ifdef INT_ARBITER_NMI_EN
    if (idx == NMI_IDX) begin
      return VEC_TOP;
    end else begin
      return VEC_TOP - offset;
    end
`else
    return VEC_TOP - offset;
`endif
  endfunction

  // Flag-clear strobe for a granted index, limited to auto-clear sources.
  function automatic logic [SRC_COUNT-1:0] clr_onehot(input logic [3:0] idx);
    logic [SRC_COUNT-1:0] mask;
    mask = {SRC_COUNT{1'b0}};
    for (int i = 0; i < SRC_COUNT; i++) begin
      if (idx == 4'(i)) begin
        mask[i] = AUTOCLR_MASK[i];
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

`ifdef INT_ARBITER_NMI_EN
  logic nmi_pend_q, nmi_pend_d;
  logic nmi_prev_q, nmi_prev_d;

  // NMI pending flag: set on an NMIreq rising edge, cleared once the NMI
  // grant reaches CLEAR; a new edge in that same cycle wins.
  always_comb begin
    nmi_prev_d = NMIreq;
    nmi_pend_d = nmi_pend_q;
    if (NMIreq && !nmi_prev_q) begin
      nmi_pend_d = 1'b1;
    end else if (state_q == ST_CLEAR && intidx_q == NMI_IDX) begin
      nmi_pend_d = 1'b0;
    end else begin
      nmi_pend_d = nmi_pend_q;
    end
  end

  // NMI edge detector and pending flag registers.
  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b0;
    end else begin
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  assign nmi_pend_s = nmi_pend_q;
`else
  assign nmi_pend_s = 1'b0;
`endif

  // Priority pick: highest set request index, overridden by a pending NMI.
  always_comb begin
    pick_s = 4'h0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      if (INTreq[i]) begin
        pick_s = 4'(i);
      end else begin
        pick_s = pick_s;
      end
    end
    if (nmi_pend_s) begin
      pick_s = NMI_IDX;
    end else begin
      pick_s = pick_s;
    end
  end

  // IRQ is raised only in IDLE, and is forced low while reset is held.
  assign irq_s = RSTn && (state_q == ST_IDLE) && ((GIE && |INTreq) || nmi_pend_s);

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_d    = state_q;
    intidx_d   = intidx_q;
    cnt_d      = cnt_q;
    vecvalid_d = 1'b0;
    vecaddr_d  = 16'h0000;
    intclr_d   = {SRC_COUNT{1'b0}};
    toerr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INTack && irq_s) begin
          state_d    = ST_GRANT;
          intidx_d   = pick_s;
          cnt_d      = 4'h0;
          vecvalid_d = 1'b1;
          vecaddr_d  = vec_addr(pick_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        cnt_d = cnt_q + 4'h1;
        if (VECread) begin
          state_d  = ST_CLEAR;
          intclr_d = clr_onehot(intidx_q);
        end else if (cnt_q + 4'h1 == TIMEOUT_C) begin
          state_d = ST_HOLD;
          toerr_d = 1'b1;
        end else begin
          state_d    = ST_GRANT;
          vecvalid_d = 1'b1;
          vecaddr_d  = vecaddr_q;
        end
      end
      ST_CLEAR: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset forces IDLE with outputs low.
  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      intidx_q   <= 4'h0;
      cnt_q      <= 4'h0;
      vecvalid_q <= 1'b0;
      vecaddr_q  <= 16'h0000;
      intclr_q   <= {SRC_COUNT{1'b0}};
      toerr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      intidx_q   <= intidx_d;
      cnt_q      <= cnt_d;
      vecvalid_q <= vecvalid_d;
      vecaddr_q  <= vecaddr_d;
      intclr_q   <= intclr_d;
      toerr_q    <= toerr_d;
    end
  end

  assign IRQ      = irq_s;
  assign VECvalid = vecvalid_q;
  assign VECaddr  = vecaddr_q;
  assign INTidx   = intidx_q;
  assign INTclr   = intclr_q;
  assign TOerr    = toerr_q;

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter SRC_COUNT, default 8, SHALL set the number of maskable request lines (legal 1..15).
REQ-002 Parameter VEC_TOP, default 16'hFFFC, SHALL set the highest vector address in the table.
REQ-003 Parameter AUTOCLR_MASK, default 0 (width SRC_COUNT), SHALL mark which sources get an automatic flag clear on acceptance.
REQ-004 Parameter TIMEOUT, default 15, SHALL set the maximum number of GRANT cycles waited for VECread (legal 1..15).
REQ-005 MCLK  in  1  system clock; all state SHALL change on its rising edge.
REQ-006 RSTn  in  1  asynchronous, active-low reset.
REQ-007 INTreq  in  SRC_COUNT  level requests (e.g. TAxINT0/TAxINT1); a higher index SHALL mean higher priority.
REQ-008 GIE  in  1  global interrupt enable from the status register.
REQ-009 INTack  in  1  one-cycle CPU pulse at an instruction boundary accepting the interrupt.
REQ-010 VECread  in  1  one-cycle CPU pulse when the vector word is fetched.
REQ-011 IRQ  out  1  interrupt request to the CPU.
REQ-012 VECvalid  out  1  VECaddr holds a granted vector.
REQ-013 VECaddr  out  16  vector address of the granted source.
REQ-014 INTidx  out  4  granted source index (4'hF = NMI).
REQ-015 INTclr  out  SRC_COUNT  one-cycle flag-clear strobes to the sources (drives TAxCLR0-style inputs).
REQ-016 TOerr  out  1  one-cycle pulse on handshake timeout.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, CLEAR and HOLD, encoded in 2 bits.
REQ-018 In IDLE, IRQ SHALL be combinationally high when GIE & |INTreq is true; IRQ SHALL be low in all other states.
REQ-019 In IDLE, INTack while IRQ=1 SHALL latch the highest-index set INTreq bit as sampled in that same cycle into INTidx, and SHALL move to GRANT on the next edge.
REQ-020 INTack while IRQ=0 SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-021 In GRANT: VECvalid=1 and VECaddr = VEC_TOP - 2*(SRC_COUNT - INTidx), using 16-bit modulo arithmetic; the latched grant SHALL NOT change even if INTreq changes.
REQ-022 In GRANT, VECread SHALL cause a move to CLEAR; VECread in any other state SHALL be ignored.
REQ-023 A 4-bit counter SHALL clear on GRANT entry and increment each GRANT cycle; if it reaches TIMEOUT without VECread, then TOerr=1 for one cycle, no INTclr is issued, and the FSM moves to HOLD.
REQ-024 In CLEAR, INTclr[INTidx] SHALL be high for exactly one cycle when AUTOCLR_MASK[INTidx]=1, and all INTclr bits SHALL be 0 otherwise; the next state SHALL be HOLD.
REQ-025 HOLD SHALL last exactly one cycle with IRQ=0, so that cleared flags propagate, and SHALL then return to IDLE.
REQ-026 VECvalid SHALL be 0 outside GRANT, and VECaddr SHALL be 16'h0000 outside GRANT.
REQ-027 Minimum accept-to-re-request spacing SHALL be 4 cycles: INTack, GRANT, CLEAR, HOLD.

Reset
REQ-028 Asserting RSTn low SHALL force IDLE at any time, including mid-GRANT, and SHALL clear INTidx, the counter and the NMI pending flag.
REQ-029 While RSTn=0, all outputs SHALL be 0.
REQ-030 After RSTn deasserts, the first IRQ SHALL be able to assert in the first cycle after release.

Configuration
REQ-031 When macro INT_ARBITER_NMI_EN is defined, the block SHALL have input NMIreq (1 bit).
REQ-032 With INT_ARBITER_NMI_EN defined, a rising edge on NMIreq SHALL set an NMI pending flag; NMI SHALL outrank all INTreq bits and SHALL ignore GIE; its grant SHALL give INTidx=4'hF and VECaddr=VEC_TOP; the pending flag SHALL clear in CLEAR; no INTclr bit SHALL pulse for an NMI grant.
REQ-033 Without INT_ARBITER_NMI_EN, the NMIreq port and the pending flag SHALL be absent, and VEC_TOP SHALL never be output.

Verification
REQ-034 SRC_COUNT=8, GIE=1, INTreq=8'h05, pulse INTack -> next cycle VECvalid=1, INTidx=2, VECaddr=16'hFFF0.
REQ-035 Same grant, AUTOCLR_MASK=8'h04, pulse VECread -> INTclr=8'h04 for exactly one cycle, then IRQ=0 for one HOLD cycle, then IRQ=1 again (INTreq held).
REQ-036 GIE=0, INTreq=8'hFF, pulse INTack -> IRQ=0, FSM stays IDLE, VECvalid remains 0.
REQ-037 TIMEOUT=3, grant with no VECread -> TOerr pulse after 3 GRANT cycles, INTclr stays 0, FSM returns to IDLE 1 cycle later.
REQ-038 INT_ARBITER_NMI_EN defined, GIE=0, NMIreq rising edge together with INTreq=8'h80 -> IRQ=1; INTack -> INTidx=4'hF, VECaddr=16'hFFFC.
REQ-039 RSTn pulsed low during GRANT -> all outputs 0 immediately; after release with INTreq=0, IRQ=0.
